// File: rtl/vga_pkg.sv
// Shared types for the VGA raster timing engine: segment encoding,
// per-axis size record and default widths.
package vga_pkg;

  localparam int VGA_H_WIDTH   = 12;
  localparam int VGA_V_WIDTH   = 12;
  localparam int VGA_DIV_WIDTH = 8;
  // Storage width of one size field in the axis config record; every
  // axis width used by the engine must not exceed it.
  localparam int VGA_CFG_W     = 16;

  typedef enum logic [1:0] {
    SEG_ACT  = 2'd0,
    SEG_FP   = 2'd1,
    SEG_SYNC = 2'd2,
    SEG_BP   = 2'd3
  } vga_seg_e;

  typedef struct packed {
    logic [VGA_CFG_W-1:0] act;
    logic [VGA_CFG_W-1:0] fp;
    logic [VGA_CFG_W-1:0] sn;
    logic [VGA_CFG_W-1:0] bp;
  } vga_axis_cfg_t;

  // Length of one segment of an axis.
  function automatic logic [VGA_CFG_W-1:0] seg_len(input vga_axis_cfg_t cfg, input vga_seg_e seg);
    logic [VGA_CFG_W-1:0] len;
    case (seg)
      SEG_ACT:  len = cfg.act;
      SEG_FP:   len = cfg.fp;
      SEG_SYNC: len = cfg.sn;
      default:  len = cfg.bp;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// One raster axis: walks ACT -> FP -> SYNC -> BP -> ACT, counting the
// position inside the current segment. Empty segments are skipped in
// the same step, so a zero-length porch costs no cycle.
module vga_timing_axis
  import vga_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              step_i,
  input  logic              clr_i,
  input  vga_axis_cfg_t     cfg_i,
  output vga_seg_e          seg_o,
  output logic [WIDTH-1:0]  pos_o,
  output logic              wrap_o
);

  vga_seg_e             seg_reg;
  vga_seg_e             seg_next;
  vga_seg_e             seg_p1;
  vga_seg_e             seg_p2;
  vga_seg_e             seg_p3;
  logic [WIDTH-1:0]     pos_reg;
  logic [VGA_CFG_W-1:0] cur_len;
  logic                 last_pos;

  assign seg_p1 = vga_seg_e'(2'(seg_reg) + 2'd1);
  assign seg_p2 = vga_seg_e'(2'(seg_reg) + 2'd2);
  assign seg_p3 = vga_seg_e'(2'(seg_reg) + 2'd3);

  assign cur_len  = seg_len(cfg_i, seg_reg);
  // Compare one bit wider than the stored length so pos+1 cannot wrap.
  assign last_pos = ((VGA_CFG_W+1)'(pos_reg) + (VGA_CFG_W+1)'(1)) >= {1'b0, cur_len};

  // Next non-empty segment; falls back to ACT when every other segment is empty.
  always_comb begin
    seg_next = SEG_ACT;
    if (seg_len(cfg_i, seg_p1) != '0)
      seg_next = seg_p1;
    else if (seg_len(cfg_i, seg_p2) != '0)
      seg_next = seg_p2;
    else if (seg_len(cfg_i, seg_p3) != '0)
      seg_next = seg_p3;
  end

  // Segment/position state; clear wins over step.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      seg_reg <= SEG_ACT;
      pos_reg <= '0;
    end else if (clr_i) begin
      seg_reg <= SEG_ACT;
      pos_reg <= '0;
    end else if (step_i) begin
      if (last_pos) begin
        seg_reg <= seg_next;
        pos_reg <= '0;
      end else begin
        pos_reg <= pos_reg + 1'b1;
      end
    end
  end

  assign seg_o  = seg_reg;
  assign pos_o  = pos_reg;
  assign wrap_o = last_pos && (seg_next == SEG_ACT);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing engine: pixel-clock divider, shadowed geometry and
// polarity, two axis walkers (H stepped per pixel, V per line) and the
// registered pin-side outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_WIDTH   = VGA_H_WIDTH,
  parameter int V_WIDTH   = VGA_V_WIDTH,
  parameter int DIV_WIDTH = VGA_DIV_WIDTH
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 hpol_i,
  input  logic                 vpol_i,
  input  logic [H_WIDTH-1:0]   hvsize_i,
  input  logic [H_WIDTH-1:0]   hfpsize_i,
  input  logic [H_WIDTH-1:0]   hsnsize_i,
  input  logic [H_WIDTH-1:0]   hbpsize_i,
  input  logic [V_WIDTH-1:0]   vvsize_i,
  input  logic [V_WIDTH-1:0]   vfpsize_i,
  input  logic [V_WIDTH-1:0]   vsnsize_i,
  input  logic [V_WIDTH-1:0]   vbpsize_i,
  output logic                 pix_en_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [H_WIDTH-1:0]   hcnt_o,
  output logic [V_WIDTH-1:0]   vcnt_o,
  output logic                 line_start_o,
  output logic                 frame_start_o
);

  logic                 en_d;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  logic                 degenerate;
  logic                 capture;

  logic [H_WIDTH-1:0]   hv_sh, hfp_sh, hsn_sh, hbp_sh;
  logic [V_WIDTH-1:0]   vv_sh, vfp_sh, vsn_sh, vbp_sh;
  logic                 hpol_sh, vpol_sh;

  vga_axis_cfg_t        h_cfg, v_cfg;
  vga_seg_e             h_seg, v_seg;
  logic [H_WIDTH-1:0]   h_pos;
  logic [V_WIDTH-1:0]   v_pos;
  logic                 h_wrap, v_wrap;
  logic                 axis_clr;
  logic                 h_act, v_act;

  // The cycle en_i rises only loads the shadow; pixels start the cycle after,
  // so the first strobe already sees the freshly captured geometry.
  // ">=" rather than "==" keeps the strobe running if div_i is lowered mid-count.
  assign tick       = en_i && en_d && (div_cnt >= div_i);
  assign degenerate = (hv_sh == '0) || (vv_sh == '0);
  // While degenerate there is no frame end, so every strobe counts as one;
  // otherwise a new geometry could never be picked up without toggling en_i.
  assign capture    = (en_i && !en_d) || (tick && (degenerate || (h_wrap && v_wrap)));
  assign axis_clr   = !en_i || degenerate;

  assign h_act = (h_seg == SEG_ACT);
  assign v_act = (v_seg == SEG_ACT);

  // Enable history used for rising-edge detection.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) en_d <= 1'b0;
    else          en_d <= en_i;
  end

  // Pixel-clock divider: one strobe every div_i+1 cycles.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)               div_cnt <= '0;
    else if (!en_i || !en_d)    div_cnt <= '0;
    else if (tick)              div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  // Shadow geometry/polarity, reloaded only at enable and at frame boundaries.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      hv_sh <= '0; hfp_sh <= '0; hsn_sh <= '0; hbp_sh <= '0;
      vv_sh <= '0; vfp_sh <= '0; vsn_sh <= '0; vbp_sh <= '0;
      hpol_sh <= 1'b0;
      vpol_sh <= 1'b0;
    end else if (capture) begin
      hv_sh <= hvsize_i; hfp_sh <= hfpsize_i; hsn_sh <= hsnsize_i; hbp_sh <= hbpsize_i;
      vv_sh <= vvsize_i; vfp_sh <= vfpsize_i; vsn_sh <= vsnsize_i; vbp_sh <= vbpsize_i;
      hpol_sh <= hpol_i;
      vpol_sh <= vpol_i;
    end
  end

  // Widen the shadow sizes into the axis config records.
  always_comb begin
    h_cfg = '{act: VGA_CFG_W'(hv_sh), fp: VGA_CFG_W'(hfp_sh),
              sn:  VGA_CFG_W'(hsn_sh), bp: VGA_CFG_W'(hbp_sh)};
    v_cfg = '{act: VGA_CFG_W'(vv_sh), fp: VGA_CFG_W'(vfp_sh),
              sn:  VGA_CFG_W'(vsn_sh), bp: VGA_CFG_W'(vbp_sh)};
  end

  vga_timing_axis #(.WIDTH(H_WIDTH)) u_h_axis (
    .pclk    (pclk),
    .presetn (presetn),
    .step_i  (tick),
    .clr_i   (axis_clr),
    .cfg_i   (h_cfg),
    .seg_o   (h_seg),
    .pos_o   (h_pos),
    .wrap_o  (h_wrap)
  );

  vga_timing_axis #(.WIDTH(V_WIDTH)) u_v_axis (
    .pclk    (pclk),
    .presetn (presetn),
    .step_i  (tick && h_wrap),
    .clr_i   (axis_clr),
    .cfg_i   (v_cfg),
    .seg_o   (v_seg),
    .pos_o   (v_pos),
    .wrap_o  (v_wrap)
  );

  // Output flops: on each strobe they present the position the axes are
  // leaving; pulses last a single cycle, levels hold between strobes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pix_en_o      <= 1'b0;
      hsync_o       <= 1'b1;
      vsync_o       <= 1'b1;
      de_o          <= 1'b0;
      hcnt_o        <= '0;
      vcnt_o        <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (!en_i) begin
      pix_en_o      <= 1'b0;
      hsync_o       <= ~hpol_i;
      vsync_o       <= ~vpol_i;
      de_o          <= 1'b0;
      hcnt_o        <= '0;
      vcnt_o        <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (tick) begin
      pix_en_o <= 1'b1;
      if (degenerate) begin
        hsync_o       <= ~hpol_sh;
        vsync_o       <= ~vpol_sh;
        de_o          <= 1'b0;
        hcnt_o        <= '0;
        vcnt_o        <= '0;
        line_start_o  <= 1'b0;
        frame_start_o <= 1'b0;
      end else begin
        hsync_o       <= hpol_sh ^ ~(h_seg == SEG_SYNC);
        vsync_o       <= vpol_sh ^ ~(v_seg == SEG_SYNC);
        de_o          <= h_act && v_act;
        hcnt_o        <= h_act ? h_pos : '0;
        vcnt_o        <= v_act ? v_pos : '0;
        line_start_o  <= h_act && (h_pos == '0);
        frame_start_o <= h_act && (h_pos == '0) && v_act && (v_pos == '0);
      end
    end else begin
      pix_en_o      <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a raster model built on flat pixel/line
// indices checks every output each cycle, and per-frame measurements are
// pinned against hand-computed numbers.
module tb_vga_timing_gen;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        en_i;
  logic [7:0]  div_i;
  logic        hpol_i, vpol_i;
  logic [11:0] hvsize_i, hfpsize_i, hsnsize_i, hbpsize_i;
  logic [11:0] vvsize_i, vfpsize_i, vsnsize_i, vbpsize_i;
  logic        pix_en_o, hsync_o, vsync_o, de_o, line_start_o, frame_start_o;
  logic [11:0] hcnt_o, vcnt_o;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.H_WIDTH(12), .V_WIDTH(12), .DIV_WIDTH(8)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .en_i          (en_i),
    .div_i         (div_i),
    .hpol_i        (hpol_i),
    .vpol_i        (vpol_i),
    .hvsize_i      (hvsize_i),
    .hfpsize_i     (hfpsize_i),
    .hsnsize_i     (hsnsize_i),
    .hbpsize_i     (hbpsize_i),
    .vvsize_i      (vvsize_i),
    .vfpsize_i     (vfpsize_i),
    .vsnsize_i     (vsnsize_i),
    .vbpsize_i     (vbpsize_i),
    .pix_en_o      (pix_en_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .de_o          (de_o),
    .hcnt_o        (hcnt_o),
    .vcnt_o        (vcnt_o),
    .line_start_o  (line_start_o),
    .frame_start_o (frame_start_o)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (flat raster indices) ----------------
  int   s_hv, s_hfp, s_hsn, s_hbp, s_vv, s_vfp, s_vsn, s_vbp;
  logic s_hpol, s_vpol;
  int   m_line_len, m_frame_len;
  int   mx, my;
  logic m_en_d;
  logic [7:0] m_div;
  logic m_tick;
  logic e_pix, e_hs, e_vs, e_de, e_ls, e_fs;
  logic [11:0] e_hc, e_vc;

  always_comb begin
    m_line_len  = s_hv + s_hfp + s_hsn + s_hbp;
    m_frame_len = s_vv + s_vfp + s_vsn + s_vbp;
    m_tick      = en_i && m_en_d && (m_div == div_i);
  end

  task automatic m_capture();
    s_hv <= int'(hvsize_i);  s_hfp <= int'(hfpsize_i);
    s_hsn <= int'(hsnsize_i); s_hbp <= int'(hbpsize_i);
    s_vv <= int'(vvsize_i);  s_vfp <= int'(vfpsize_i);
    s_vsn <= int'(vsnsize_i); s_vbp <= int'(vbpsize_i);
    s_hpol <= hpol_i; s_vpol <= vpol_i;
  endtask

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s_hv <= 0; s_hfp <= 0; s_hsn <= 0; s_hbp <= 0;
      s_vv <= 0; s_vfp <= 0; s_vsn <= 0; s_vbp <= 0;
      s_hpol <= 1'b0; s_vpol <= 1'b0;
      mx <= 0; my <= 0; m_en_d <= 1'b0; m_div <= 8'd0;
      e_pix <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1; e_de <= 1'b0;
      e_hc <= 12'd0; e_vc <= 12'd0; e_ls <= 1'b0; e_fs <= 1'b0;
    end else if (!en_i) begin
      mx <= 0; my <= 0; m_en_d <= 1'b0; m_div <= 8'd0;
      e_pix <= 1'b0; e_hs <= !hpol_i; e_vs <= !vpol_i; e_de <= 1'b0;
      e_hc <= 12'd0; e_vc <= 12'd0; e_ls <= 1'b0; e_fs <= 1'b0;
    end else begin
      m_en_d <= 1'b1;
      if (!m_en_d) m_capture();
      m_div <= (!m_en_d || m_tick) ? 8'd0 : m_div + 8'd1;
      e_pix <= m_tick;
      e_ls  <= 1'b0;
      e_fs  <= 1'b0;
      if (m_tick) begin
        if (s_hv == 0 || s_vv == 0) begin
          e_de <= 1'b0; e_hc <= 12'd0; e_vc <= 12'd0;
          e_hs <= !s_hpol; e_vs <= !s_vpol;
          m_capture();
        end else begin
          e_de <= (mx < s_hv) && (my < s_vv);
          e_hc <= (mx < s_hv) ? 12'(mx) : 12'd0;
          e_vc <= (my < s_vv) ? 12'(my) : 12'd0;
          e_hs <= ((mx >= s_hv + s_hfp) && (mx < s_hv + s_hfp + s_hsn)) ? s_hpol : !s_hpol;
          e_vs <= ((my >= s_vv + s_vfp) && (my < s_vv + s_vfp + s_vsn)) ? s_vpol : !s_vpol;
          e_ls <= (mx == 0);
          e_fs <= (mx == 0) && (my == 0);
          if (mx == m_line_len - 1) begin
            mx <= 0;
            if (my == m_frame_len - 1) begin
              my <= 0;
              m_capture();
            end else begin
              my <= my + 1;
            end
          end else begin
            mx <= mx + 1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge pclk) begin
    chk("pix_en", pix_en_o, e_pix);
    chk("hsync", hsync_o, e_hs);
    chk("vsync", vsync_o, e_vs);
    chk("de", de_o, e_de);
    chk("hcnt", hcnt_o, e_hc);
    chk("vcnt", vcnt_o, e_vc);
    chk("line_start", line_start_o, e_ls);
    chk("frame_start", frame_start_o, e_fs);
  end

  // ---------------- frame measurement ----------------
  task automatic measure(input int chg_at, output int period, output int de_n,
                         output int hs_low, output int vs_low, output int pix_n,
                         output int hs_after_de);
    int   wait_n;
    logic prev_de, prev_hs;
    period = 0; de_n = 0; hs_low = 0; vs_low = 0; pix_n = 0; hs_after_de = 0; wait_n = 0;
    while (frame_start_o !== 1'b1 && wait_n < 1000) begin
      @(negedge pclk);
      wait_n++;
    end
    if (frame_start_o !== 1'b1) begin
      chk("frame_start_wait", 32'd0, 32'd1);
      return;
    end
    prev_de = 1'b0;
    prev_hs = hsync_o;
    do begin
      if (de_o) de_n++;
      if (!hsync_o) hs_low++;
      if (!vsync_o) vs_low++;
      if (pix_en_o) pix_n++;
      if (prev_hs && !hsync_o && prev_de) hs_after_de++;
      prev_de = de_o;
      prev_hs = hsync_o;
      @(negedge pclk);
      period++;
      if (period == chg_at) hvsize_i = 12'd6;
    end while (frame_start_o !== 1'b1 && period < 1000);
    if (period >= 1000) chk("frame_period_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_pix(output logic seen);
    int n;
    n = 0;
    @(negedge pclk);
    while (pix_en_o !== 1'b1 && n < 100) begin
      @(negedge pclk);
      n++;
    end
    seen = (pix_en_o === 1'b1);
    if (!seen) chk("pix_en_wait", 32'd0, 32'd1);
  endtask

  task automatic restart();
    @(negedge pclk);
    en_i = 1'b0;
    @(negedge pclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  int   p, d, hl, vl, pc, had, n;
  logic seen;

  initial begin
    presetn = 1'b0; en_i = 1'b0; div_i = 8'd0; hpol_i = 1'b0; vpol_i = 1'b0;
    hvsize_i = 12'd4; hfpsize_i = 12'd1; hsnsize_i = 12'd2; hbpsize_i = 12'd1;
    vvsize_i = 12'd3; vfpsize_i = 12'd1; vsnsize_i = 12'd1; vbpsize_i = 12'd1;
    repeat (3) @(negedge pclk);
    chk("rst_hsync", hsync_o, 32'd1);
    chk("rst_vsync", vsync_o, 32'd1);
    chk("rst_de", de_o, 32'd0);
    chk("rst_pix_en", pix_en_o, 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // Basic timing, divider off.
    en_i = 1'b1;
    measure(-1, p, d, hl, vl, pc, had);
    chk("t1_period", p, 32'd48); chk("t1_de", d, 32'd12);
    chk("t1_hs_low", hl, 32'd12); chk("t1_vs_low", vl, 32'd8);
    chk("t1_pix", pc, 32'd48);  chk("t1_hs_after_de", had, 32'd0);
    $display("T1 div=0 period=%0d de=%0d hs_low=%0d vs_low=%0d", p, d, hl, vl);

    // Divide by 3.
    restart(); div_i = 8'd2; en_i = 1'b1;
    measure(-1, p, d, hl, vl, pc, had);
    chk("t2_period", p, 32'd144); chk("t2_de", d, 32'd36);
    chk("t2_hs_low", hl, 32'd36); chk("t2_vs_low", vl, 32'd24);
    chk("t2_pix", pc, 32'd48);
    $display("T2 div=2 period=%0d de=%0d pix=%0d", p, d, pc);

    // Zero-length front porch (H) and back porch (V).
    restart(); div_i = 8'd0; hfpsize_i = 12'd0; vbpsize_i = 12'd0; en_i = 1'b1;
    measure(-1, p, d, hl, vl, pc, had);
    chk("t3_period", p, 32'd35); chk("t3_de", d, 32'd12);
    chk("t3_hs_low", hl, 32'd10); chk("t3_vs_low", vl, 32'd7);
    chk("t3_hs_after_de", had, 32'd3);
    $display("T3 zero porches period=%0d hs_after_de=%0d", p, had);

    // Mid-frame active-width change takes effect next frame only.
    restart(); hfpsize_i = 12'd1; vbpsize_i = 12'd1; en_i = 1'b1;
    measure(10, p, d, hl, vl, pc, had);
    chk("t4_old_period", p, 32'd48); chk("t4_old_de", d, 32'd12);
    measure(-1, p, d, hl, vl, pc, had);
    chk("t4_new_period", p, 32'd60); chk("t4_new_de", d, 32'd18);
    chk("t4_new_hs_low", hl, 32'd12);
    $display("T4 hvsize 4->6 new period=%0d de=%0d", p, d);

    // Disable mid-line, then re-enable.
    n = 0;
    while (de_o !== 1'b1 && n < 100) begin @(negedge pclk); n++; end
    chk("t5_de_seen", de_o, 32'd1);
    repeat (2) @(negedge pclk);
    en_i = 1'b0;
    @(negedge pclk);
    chk("t5_off_de", de_o, 32'd0); chk("t5_off_hcnt", hcnt_o, 32'd0);
    chk("t5_off_vcnt", vcnt_o, 32'd0); chk("t5_off_hsync", hsync_o, 32'd1);
    chk("t5_off_vsync", vsync_o, 32'd1);
    en_i = 1'b1;
    wait_pix(seen);
    chk("t5_fs", frame_start_o, 32'd1); chk("t5_ls", line_start_o, 32'd1);
    chk("t5_hcnt", hcnt_o, 32'd0); chk("t5_vcnt", vcnt_o, 32'd0);
    chk("t5_de", de_o, 32'd1);
    $display("T5 re-enable fs=%0d ls=%0d de=%0d", frame_start_o, line_start_o, de_o);

    // Polarity change latched at frame end.
    hpol_i = 1'b1; vpol_i = 1'b1;
    measure(-1, p, d, hl, vl, pc, had);
    chk("t6_oldpol_hs_low", hl, 32'd12); chk("t6_oldpol_vs_low", vl, 32'd10);
    measure(-1, p, d, hl, vl, pc, had);
    chk("t6_newpol_hs_low", hl, 32'd48); chk("t6_newpol_vs_low", vl, 32'd50);
    $display("T6 pol=1 frame hs_low=%0d vs_low=%0d", hl, vl);

    // Asynchronous reset in the middle of a frame.
    repeat (25) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    chk("t6_rst_hsync", hsync_o, 32'd1); chk("t6_rst_vsync", vsync_o, 32'd1);
    chk("t6_rst_de", de_o, 32'd0); chk("t6_rst_hcnt", hcnt_o, 32'd0);
    chk("t6_rst_pix", pix_en_o, 32'd0); chk("t6_rst_fs", frame_start_o, 32'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    wait_pix(seen);
    chk("t6_rel_fs", frame_start_o, 32'd1);
    $display("T6 reset release first strobe fs=%0d", frame_start_o);

    repeat (3) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
